// File: rtl/clock_set_controller.sv
// clock_set_controller: front-panel time-set sequencer (mode FSM, stop, inc/dec/clear strobes, auto-repeat, blink, idle timeout)
//   in : clk_100MHz, reset_n (async active-low), btn_mode/btn_up/btn_down (debounced levels)
//   out: stop, field_sel[1:0], tick_hr_inc/dec, tick_min_inc/dec, sec_clear, blink
module clock_set_controller #(
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int REPEAT_CYCLES  = 10_000_000,
  parameter int BLINK_CYCLES   = 25_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000_000,
  parameter int CNT_W          = 32
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       stop,
  output logic [1:0] field_sel,
  output logic       tick_hr_inc,
  output logic       tick_hr_dec,
  output logic       tick_min_inc,
  output logic       tick_min_dec,
  output logic       sec_clear,
  output logic       blink
);
  localparam logic [1:0] RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3;
  localparam logic [CNT_W-1:0] L_HOLD    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] L_RELOAD  = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] L_BLINK   = CNT_W'(BLINK_CYCLES);
  localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
  logic [1:0]       r_state;
  logic             r_mode_prev, r_up_prev, r_dn_prev, r_arm, r_blink;
  logic             r_hr_inc, r_hr_dec, r_min_inc, r_min_dec, r_sec_clr;
  logic [CNT_W-1:0] r_rep, r_bcnt, r_idle;
  logic             w_mode_rise, w_up_rise, w_dn_rise, w_up_only, w_dn_only, w_one;
  logic             w_set, w_fine, w_timeout, w_chg, w_adj, w_press, w_rpt, w_strobe;
  logic             w_sec_clr, w_any, w_set_nx, w_count;
  logic [1:0]       w_state_nx;
  logic [CNT_W-1:0] w_rep_nx, w_bcnt_nx, w_idle_nx;
  assign w_mode_rise = btn_mode & ~r_mode_prev;
  assign w_up_rise   = btn_up & ~r_up_prev;
  assign w_dn_rise   = btn_down & ~r_dn_prev;
  assign w_up_only   = btn_up & ~btn_down;
  assign w_dn_only   = btn_down & ~btn_up;
  assign w_one       = w_up_only | w_dn_only;
  assign w_set       = r_state != RUN;
  assign w_fine      = (r_state == SET_HR) | (r_state == SET_MIN);
  assign w_rep_nx    = r_rep + CNT_W'(1);
  assign w_bcnt_nx   = r_bcnt + CNT_W'(1);
  assign w_idle_nx   = r_idle + CNT_W'(1);
  // any held up/down counts as activity, so only a fully idle panel can time out
  assign w_timeout   = w_set & ~w_mode_rise & ~btn_up & ~btn_down & (w_idle_nx == L_TIMEOUT);
  assign w_state_nx  = w_mode_rise ? r_state + 2'd1 : w_timeout ? RUN : r_state;
  assign w_chg       = w_state_nx != r_state;
  assign w_set_nx    = w_state_nx != RUN;
  // no adjusting on a cycle where the mode changes: mode wins
  assign w_adj       = w_set & ~w_chg;
  // a rise only counts when the other button is not held
  assign w_press     = (w_up_rise & w_up_only) | (w_dn_rise & w_dn_only);
  // r_arm marks a button whose press was accepted in this state; only it may auto-repeat
  assign w_count     = w_adj & w_fine & w_one & r_arm & ~w_press;
  // after the first repeat the counter reloads so the next hit is REPEAT_CYCLES later
  assign w_rpt       = w_count & (w_rep_nx == L_HOLD);
  assign w_strobe    = w_adj & w_fine & (w_press | w_rpt);
  assign w_sec_clr   = w_adj & (r_state == SET_SEC) & w_press;
  assign w_any       = w_strobe | w_sec_clr;
  always_ff @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) begin
      r_state     <= RUN;
      r_mode_prev <= 1'b1;
      r_up_prev   <= 1'b1;
      r_dn_prev   <= 1'b1;
      r_arm       <= 1'b0;
      r_rep       <= '0;
      r_bcnt      <= '0;
      r_idle      <= '0;
      r_blink     <= 1'b0;
      r_hr_inc    <= 1'b0;
      r_hr_dec    <= 1'b0;
      r_min_inc   <= 1'b0;
      r_min_dec   <= 1'b0;
      r_sec_clr   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_mode_prev <= btn_mode;
      r_up_prev   <= btn_up;
      r_dn_prev   <= btn_down;
      r_arm       <= (w_chg | ~w_one) ? 1'b0 : (w_adj & w_fine & w_press) ? 1'b1 : r_arm;
      r_rep       <= ~w_count ? '0 : w_rpt ? L_RELOAD : w_rep_nx;
      r_blink     <= ~w_set_nx ? 1'b0 : (w_chg | w_any) ? 1'b1 : (w_bcnt_nx == L_BLINK) ? ~r_blink : r_blink;
      r_bcnt      <= (~w_set_nx | w_chg | w_any | (w_bcnt_nx == L_BLINK)) ? '0 : w_bcnt_nx;
      r_idle      <= (~w_set_nx | w_chg | w_mode_rise | btn_up | btn_down) ? '0 : w_idle_nx;
      r_hr_inc    <= w_strobe & (r_state == SET_HR) & w_up_only;
      r_hr_dec    <= w_strobe & (r_state == SET_HR) & w_dn_only;
      r_min_inc   <= w_strobe & (r_state == SET_MIN) & w_up_only;
      r_min_dec   <= w_strobe & (r_state == SET_MIN) & w_dn_only;
      r_sec_clr   <= w_sec_clr;
    end
  assign stop         = r_state != RUN;
  assign field_sel    = r_state;
  assign tick_hr_inc  = r_hr_inc;
  assign tick_hr_dec  = r_hr_dec;
  assign tick_min_inc = r_min_inc;
  assign tick_min_dec = r_min_dec;
  assign sec_clear    = r_sec_clr;
  assign blink        = r_blink;
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: directed plan plus random stimulus against a behavioural model of the set controller
module tb_clock_set_controller;
  localparam int HOLD = 8, REPEAT = 4, BLINK = 5, TIMEOUT = 40;
  logic clk = 1'b0, reset_n = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic stop, tick_hr_inc, tick_hr_dec, tick_min_inc, tick_min_dec, sec_clear, blink;
  logic [1:0] field_sel;
  int total = 0, bad = 0, cyc_no = 0;
  int n_hri, n_hrd, n_mi, n_md, n_sec;
  // model state: selected field, previous levels, armed hold age, blink age, idle age
  int st, pm, pu, pd, armed, age, bage, idle;
  logic [8:0] e;
  clock_set_controller #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT), .BLINK_CYCLES(BLINK),
    .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(32)) dut (
    .clk_100MHz(clk), .reset_n(reset_n), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .stop(stop), .field_sel(field_sel), .tick_hr_inc(tick_hr_inc), .tick_hr_dec(tick_hr_dec),
    .tick_min_inc(tick_min_inc), .tick_min_dec(tick_min_dec), .sec_clear(sec_clear), .blink(blink));
  always #5 clk = ~clk;
  function automatic logic [8:0] dut_vec();
    return {stop, field_sel, tick_hr_inc, tick_hr_dec, tick_min_inc, tick_min_dec, sec_clear, blink};
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask
  task automatic model_reset();
    st = 0; pm = 1; pu = 1; pd = 1; armed = 0; age = 0; bage = 0; idle = 0; e = '0;
  endtask
  task automatic model(input int m, input int u, input int d);
    int mr, ur, dr, one, press, nst, chg, strobe, sc;
    if (!reset_n) begin
      model_reset();
      return;
    end
    mr = m & ~pm & 1; ur = u & ~pu & 1; dr = d & ~pd & 1;
    one = u ^ d;
    press = one && ((u && ur) || (d && dr));
    nst = mr ? (st + 1) % 4 : (st != 0 && !u && !d && idle + 1 == TIMEOUT) ? 0 : st;
    chg = nst != st;
    strobe = 0; sc = 0;
    if (!chg && st == 3) sc = press;
    if (!chg && (st == 1 || st == 2)) begin
      if (press) begin
        strobe = 1; armed = 1; age = 0;
      end else if (armed && one) begin
        age++;
        strobe = (age >= HOLD) && ((age - HOLD) % REPEAT == 0);
      end
    end
    if (chg || !one) armed = 0;
    if (nst == 0 || chg || strobe || sc) bage = 0; else bage++;
    if (nst == 0 || chg || mr || u || d) idle = 0; else idle++;
    e = {nst != 0, 2'(nst),
         1'(strobe && st == 1 && u), 1'(strobe && st == 1 && d),
         1'(strobe && st == 2 && u), 1'(strobe && st == 2 && d),
         1'(sc), 1'(nst != 0 && (bage / BLINK) % 2 == 0)};
    st = nst; pm = m; pu = u; pd = d;
  endtask
  // one clock: drive on falling edge, model on rising edge, compare just after it
  task automatic cyc(input logic m, input logic u, input logic d);
    @(negedge clk);
    btn_mode = m; btn_up = u; btn_down = d;
    @(posedge clk);
    model(int'(m), int'(u), int'(d));
    #1;
    cyc_no++;
    chk("outputs{stop,field,hi,hd,mi,md,sc,blink}", int'(dut_vec()), int'(e));
    n_hri += int'(tick_hr_inc); n_hrd += int'(tick_hr_dec);
    n_mi += int'(tick_min_inc); n_md += int'(tick_min_dec); n_sec += int'(sec_clear);
  endtask
  task automatic zero_counts();
    n_hri = 0; n_hrd = 0; n_mi = 0; n_md = 0; n_sec = 0;
  endtask
  task automatic mode_press();
    cyc(1, 0, 0);
    cyc(0, 0, 0);
  endtask
  initial begin
    logic [20:0] mask;
    logic m, u, d;
    model_reset();
    zero_counts();
    repeat (3) cyc(0, 0, 0);
    chk("reset_vec", int'(dut_vec()), 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) cyc(0, 0, 0);
    // mode sequence
    cyc(1, 0, 0); chk("mode1_field", int'(field_sel), 1); chk("mode1_stop", int'(stop), 1); cyc(0, 0, 0);
    cyc(1, 0, 0); chk("mode2_field", int'(field_sel), 2); cyc(0, 0, 0);
    cyc(1, 0, 0); chk("mode3_field", int'(field_sel), 3); cyc(0, 0, 0);
    cyc(1, 0, 0); chk("mode4_field", int'(field_sel), 0); chk("mode4_stop", int'(stop), 0); cyc(0, 0, 0);
    chk("mode_no_strobes", n_hri + n_hrd + n_mi + n_md + n_sec, 0);
    // SET_MIN auto-repeat
    mode_press(); mode_press();
    zero_counts();
    mask = '0;
    for (int k = 0; k <= 20; k++) begin
      cyc(0, 1, 0);
      mask[k] = tick_min_inc;
    end
    cyc(0, 0, 0);
    chk("repeat_mask", int'(mask), 32'h111101);
    chk("repeat_hr_quiet", n_hri + n_hrd, 0);
    // SET_HR conflicts
    mode_press(); mode_press(); mode_press();
    chk("sethr_field", int'(field_sel), 1);
    zero_counts();
    cyc(0, 0, 1);
    repeat (5) cyc(0, 1, 1);
    cyc(0, 0, 0);
    chk("conflict_dec", n_hrd, 1);
    chk("conflict_inc", n_hri, 0);
    cyc(0, 1, 0); cyc(0, 0, 0);
    chk("after_conflict_inc", n_hri, 1);
    // SET_SEC clear, RUN ignores
    mode_press(); mode_press();
    zero_counts();
    cyc(0, 1, 0); cyc(0, 0, 0);
    chk("sec_clear_cnt", n_sec, 1);
    mode_press();
    zero_counts();
    cyc(0, 1, 0); cyc(0, 0, 0);
    chk("run_no_strobe", n_hri + n_hrd + n_mi + n_md + n_sec, 0);
    // blink and timeout in SET_HR
    cyc(1, 0, 0);
    for (int j = 1; j <= 10; j++) begin
      cyc(0, 0, 0);
      if (j == 4) chk("blink_j4", int'(blink), 1);
      if (j == 5) chk("blink_j5", int'(blink), 0);
      if (j == 10) chk("blink_j10", int'(blink), 1);
    end
    cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("blink_after_strobe", int'(blink), 1);
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 0, 0);
      if (i == 39) chk("before_timeout_stop", int'(stop), 1);
      if (i == 40) begin
        chk("timeout_stop", int'(stop), 0);
        chk("timeout_blink", int'(blink), 0);
        chk("timeout_field", int'(field_sel), 0);
      end
    end
    // reset while up held in SET_MIN
    mode_press(); mode_press();
    repeat (3) cyc(0, 1, 0);
    @(negedge clk); reset_n = 1'b0;
    #1;
    chk("async_reset_vec", int'(dut_vec()), 0);
    model_reset();
    repeat (3) cyc(0, 1, 0);
    @(negedge clk); reset_n = 1'b1;
    zero_counts();
    repeat (12) cyc(0, 1, 0);
    cyc(1, 1, 0);
    repeat (12) cyc(0, 1, 0);
    chk("held_through_reset_quiet", n_hri + n_hrd + n_mi + n_md + n_sec, 0);
    cyc(0, 0, 0); cyc(0, 1, 0); cyc(0, 0, 0);
    chk("repress_inc", n_hri, 1);
    // random stimulus
    m = 0; u = 0; d = 0;
    for (int i = 0; i < 4000; i++) begin
      m = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 11) == 0) u = ~u;
      if ($urandom_range(0, 11) == 0) d = ~d;
      if ($urandom_range(0, 1999) == 0) begin
        @(negedge clk); reset_n = 1'b0;
        cyc(m, u, d);
        @(negedge clk); reset_n = 1'b1;
      end
      cyc(m, u, d);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
